// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the regfile write port between ALU and load/CSR writeback.
// Optional read-port forwarding of the in-flight write: define REGFILE_ARB_BYPASS_EN.
module regfile_wr_arbiter #(
    parameter int register_count = 32,
    parameter int data_length    = 32,
    parameter int CNT_W          = 16,
    localparam int AW            = $clog2(register_count)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hold,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [AW-1:0]          req0_addr,
    input  logic [data_length-1:0] req0_data,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [AW-1:0]          req1_addr,
    input  logic [data_length-1:0] req1_data,
    output logic                   w_ctrl_reg,
    output logic [AW-1:0]          w_addr_reg,
    output logic [data_length-1:0] w_data_reg,
    input  logic [AW-1:0]          r_addr_reg1,
    input  logic [AW-1:0]          r_addr_reg2,
    input  logic [data_length-1:0] r_data_reg1,
    input  logic [data_length-1:0] r_data_reg2,
    output logic [data_length-1:0] fwd_data1,
    output logic [data_length-1:0] fwd_data2,
    output logic [CNT_W-1:0]       conflict_cnt
);

    // last_grant = 1 means req1 won the previous conflict, so req0 wins the next one
    logic                   last_grant;
    logic                   both;
    logic                   xfer;
    logic [AW-1:0]          sel_addr;
    logic [data_length-1:0] sel_data;

    assign both       = req0_valid & req1_valid;
    assign req0_ready = !hold & req0_valid & (!req1_valid | last_grant);
    assign req1_ready = !hold & req1_valid & (!req0_valid | !last_grant);
    assign xfer       = req0_ready | req1_ready;

    always_comb begin
        sel_addr = req0_addr;
        sel_data = req0_data;
        if (req1_ready) begin
            sel_addr = req1_addr;
            sel_data = req1_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ctrl_reg   <= 1'b0;
            w_addr_reg   <= '0;
            w_data_reg   <= '0;
            conflict_cnt <= '0;
            last_grant   <= 1'b1;
        end else begin
            // writes to x0 are consumed but never reach the regfile
            w_ctrl_reg <= xfer & (sel_addr != '0);
            if (xfer) begin
                w_addr_reg <= sel_addr;
                w_data_reg <= sel_data;
            end
            if (both & xfer)
                last_grant <= req1_ready;
            if (both & !hold & (conflict_cnt != '1))
                conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

`ifdef REGFILE_ARB_BYPASS_EN
    logic hit1;
    logic hit2;

    assign hit1      = w_ctrl_reg & (w_addr_reg == r_addr_reg1) & (r_addr_reg1 != '0);
    assign hit2      = w_ctrl_reg & (w_addr_reg == r_addr_reg2) & (r_addr_reg2 != '0);
    assign fwd_data1 = hit1 ? w_data_reg : r_data_reg1;
    assign fwd_data2 = hit2 ? w_data_reg : r_data_reg2;
`else
    logic unused_raddr;

    assign unused_raddr = ^{r_addr_reg1, r_addr_reg2};
    assign fwd_data1    = r_data_reg1;
    assign fwd_data2    = r_data_reg2;
`endif

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: grants, latency, x0, hold,
// round-robin, counter saturation, async reset and read forwarding.
module tb_regfile_wr_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int CW = 3;

`ifdef REGFILE_ARB_BYPASS_EN
    localparam logic [DW-1:0] FWD1_EXP = 32'h3;
`else
    localparam logic [DW-1:0] FWD1_EXP = 32'h0;
`endif

    logic          clk;
    logic          rst;
    logic          hold;
    logic          v0, v1;
    logic          r0, r1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic          w_ctrl;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic [AW-1:0] ra1, ra2;
    logic [DW-1:0] rd1, rd2;
    logic [DW-1:0] fwd1, fwd2;
    logic [CW-1:0] cnt;

    int checks;
    int errors;

    regfile_wr_arbiter #(
        .register_count(32),
        .data_length(DW),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hold(hold),
        .req0_valid(v0),
        .req0_ready(r0),
        .req0_addr(a0),
        .req0_data(d0),
        .req1_valid(v1),
        .req1_ready(r1),
        .req1_addr(a1),
        .req1_data(d1),
        .w_ctrl_reg(w_ctrl),
        .w_addr_reg(w_addr),
        .w_data_reg(w_data),
        .r_addr_reg1(ra1),
        .r_addr_reg2(ra2),
        .r_data_reg1(rd1),
        .r_data_reg2(rd2),
        .fwd_data1(fwd1),
        .fwd_data2(fwd2),
        .conflict_cnt(cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic c, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        chk({tag, ".ctrl"}, 64'(w_ctrl), 64'(c));
        chk({tag, ".addr"}, 64'(w_addr), 64'(a));
        chk({tag, ".data"}, 64'(w_data), 64'(d));
    endtask

    task automatic chk_rdy(input string tag, input logic e0, input logic e1);
        chk({tag, ".rdy0"}, 64'(r0), 64'(e0));
        chk({tag, ".rdy1"}, 64'(r1), 64'(e1));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst  = 1'b0;
        hold = 1'b0;
        v0 = 1'b0; a0 = '0; d0 = '0;
        v1 = 1'b0; a1 = '0; d1 = '0;
        ra1 = '0; ra2 = '0; rd1 = '0; rd2 = '0;

        // power-on reset
        #2 rst = 1'b1;
        #1;
        chk_w("reset", 1'b0, 5'd0, 32'h0);
        chk("reset.cnt", 64'(cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // single req0 write to reg8, observed on the read ports
        @(negedge clk);
        v0 = 1'b1; a0 = 5'd8; d0 = 32'h3;
        ra1 = 5'd8; rd1 = 32'h0; ra2 = 5'd0; rd2 = 32'h55;
        #1 chk_rdy("single", 1'b1, 1'b0);
        @(negedge clk);
        v0 = 1'b0;
        chk_w("single.n1", 1'b1, 5'd8, 32'h3);
        chk("fwd1.hit", 64'(fwd1), 64'(FWD1_EXP));
        chk("fwd2.x0", 64'(fwd2), 64'h55);
        @(negedge clk);
        chk_w("single.n2", 1'b0, 5'd8, 32'h3);
        chk("fwd1.idle", 64'(fwd1), 64'h0);

        // first conflict: req0 wins, then req1 alone
        @(negedge clk);
        v0 = 1'b1; a0 = 5'd5; d0 = 32'hA;
        v1 = 1'b1; a1 = 5'd6; d1 = 32'hB;
        #1 chk_rdy("conf1.c0", 1'b1, 1'b0);
        @(negedge clk);
        v0 = 1'b0;
        chk_w("conf1.w5", 1'b1, 5'd5, 32'hA);
        chk("conf1.cnt", 64'(cnt), 64'd1);
        #1 chk_rdy("conf1.c1", 1'b0, 1'b1);
        @(negedge clk);
        v1 = 1'b0;
        chk_w("conf1.w6", 1'b1, 5'd6, 32'hB);
        chk("conf1.cnt2", 64'(cnt), 64'd1);
        @(negedge clk);
        chk("conf1.idle", 64'(w_ctrl), 64'd0);

        // write to x0 is consumed but not committed
        @(negedge clk);
        v1 = 1'b1; a1 = 5'd0; d1 = 32'hFFFF_FFFF;
        #1 chk_rdy("x0", 1'b0, 1'b1);
        @(negedge clk);
        v1 = 1'b0;
        chk_w("x0.n1", 1'b0, 5'd0, 32'hFFFF_FFFF);

        // second conflict: round-robin hands it to req1
        @(negedge clk);
        v0 = 1'b1; a0 = 5'd1; d0 = 32'h11;
        v1 = 1'b1; a1 = 5'd2; d1 = 32'h22;
        #1 chk_rdy("conf2.c0", 1'b0, 1'b1);
        @(negedge clk);
        v1 = 1'b0;
        chk_w("conf2.w2", 1'b1, 5'd2, 32'h22);
        chk("conf2.cnt", 64'(cnt), 64'd2);
        #1 chk_rdy("conf2.c1", 1'b1, 1'b0);
        @(negedge clk);
        v0 = 1'b0;
        chk_w("conf2.w1", 1'b1, 5'd1, 32'h11);

        // hold blocks all grants and counting
        hold = 1'b1;
        v0 = 1'b1; a0 = 5'd3; d0 = 32'h33;
        v1 = 1'b1; a1 = 5'd4; d1 = 32'h44;
        for (int i = 0; i < 4; i++) begin
            #1 chk_rdy("hold", 1'b0, 1'b0);
            @(negedge clk);
            chk("hold.ctrl", 64'(w_ctrl), 64'd0);
            chk("hold.cnt", 64'(cnt), 64'd2);
        end
        hold = 1'b0;
        #1 chk_rdy("rel.c0", 1'b1, 1'b0);
        @(negedge clk);
        v0 = 1'b0;
        chk_w("rel.w3", 1'b1, 5'd3, 32'h33);
        chk("rel.cnt", 64'(cnt), 64'd3);
        #1 chk_rdy("rel.c1", 1'b0, 1'b1);
        @(negedge clk);
        v1 = 1'b0;
        chk_w("rel.w4", 1'b1, 5'd4, 32'h44);

        // counter saturates at all-ones: 3 + 6 conflicts clamps to 7
        @(negedge clk);
        v0 = 1'b1; a0 = 5'd9;  d0 = 32'h9;
        v1 = 1'b1; a1 = 5'd10; d1 = 32'h10;
        repeat (6) @(negedge clk);
        v0 = 1'b0; v1 = 1'b0;
        chk("sat.cnt", 64'(cnt), 64'd7);
        @(negedge clk);
        chk("sat.hold", 64'(cnt), 64'd7);

        // asynchronous reset kills a pending write pulse
        @(negedge clk);
        v0 = 1'b1; a0 = 5'd8; d0 = 32'h3;
        @(posedge clk);
        #2 v0 = 1'b0;
        chk("arst.pre", 64'(w_ctrl), 64'd1);
        rst = 1'b1;
        #1;
        chk_w("arst", 1'b0, 5'd0, 32'h0);
        chk("arst.cnt", 64'(cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst.post", 64'(w_ctrl), 64'd0);

        // after reset req0 wins the first conflict again
        v0 = 1'b1; a0 = 5'd12; d0 = 32'hC;
        v1 = 1'b1; a1 = 5'd13; d1 = 32'hD;
        #1 chk_rdy("arst.conf", 1'b1, 1'b0);
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0;
        chk_w("arst.w12", 1'b1, 5'd12, 32'hC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
